// File: rtl/trace_unloader.sv
// trace_unloader: freezes the NoC debug trace buffer on a host request, reads
// the captured entries out oldest-first and streams them as valid/ready words
// with a last marker. Capture is released when the stream completes or aborts.
module trace_unloader #(
  parameter  int Fpay     = 32,
  parameter  int TB_Depth = 512,
  localparam int ADDR_W   = $clog2(TB_Depth)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] tb_wr_ptr,
  input  logic              tb_wrapped,
  output logic              tb_freeze,
  output logic              tb_rd_en,
  output logic [ADDR_W-1:0] tb_rd_addr,
  input  logic [Fpay-1:0]   tb_rd_data,
  output logic [Fpay-1:0]   dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FREEZE = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_CNT = TB_Depth[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [ADDR_W:0]        remaining;   // reads still to issue
  logic [ADDR_W:0]        total;       // words in this unload
  logic [ADDR_W:0]        wcnt;        // words accepted so far
  logic [1:0][Fpay-1:0]   fifo_mem;
  logic                   wr_sel, rd_sel;
  logic [1:0]             occ;
  logic                   inflight;    // read issued last cycle, data arrives now
  logic [1:0]             pending;
  logic                   start_ok, abort_run, pop, accept, issue;

  assign start_ok   = (state == IDLE) && start && !abort;
  assign abort_run  = (state != IDLE) && abort;
  assign dout_valid = (occ != 2'd0);
  assign dout       = fifo_mem[rd_sel];
  // head of the FIFO is always word number wcnt of the unload
  assign dout_last  = dout_valid && (wcnt == total - CNT_ONE);
  assign pop        = dout_valid && dout_ready;
  assign accept     = pop && !abort_run;
  assign pending    = occ + {1'b0, inflight};
  // a word leaving this cycle frees a slot, which keeps back-to-back throughput
  assign issue      = (state == STREAM) && !abort && (remaining != '0) &&
                      ((pending < 2'd2) || pop);
  assign tb_rd_en   = issue;
  assign tb_rd_addr = rd_ptr;
  assign word_count = wcnt;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = FREEZE;
      FREEZE:  if (abort) state_nxt = IDLE;
               else if (remaining == '0) state_nxt = IDLE;
               else state_nxt = STREAM;
      STREAM:  if (abort) state_nxt = IDLE;
               else if (issue && (remaining == CNT_ONE)) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (accept && dout_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // freeze and busy cover every non-idle state
  always_comb begin
    tb_freeze = 1'b0;
    busy      = 1'b0;
    if (state != IDLE) begin
      tb_freeze = 1'b1;
      busy      = 1'b1;
    end
  end

  // read pointer, counters and the 2-entry output FIFO
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      remaining <= '0;
      total     <= '0;
      wcnt      <= '0;
      fifo_mem  <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
    end else if (abort_run) begin
      // flush; any read return still on the bus is dropped since inflight clears
      occ      <= 2'd0;
      inflight <= 1'b0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
    end else begin
      if (start_ok) begin
        wcnt <= '0;
        if (tb_wrapped) begin
          rd_ptr    <= tb_wr_ptr;
          remaining <= DEPTH_CNT;
          total     <= DEPTH_CNT;
        end else begin
          rd_ptr    <= '0;
          remaining <= {1'b0, tb_wr_ptr};
          total     <= {1'b0, tb_wr_ptr};
        end
      end
      if (issue) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        remaining <= remaining - CNT_ONE;
      end
      inflight <= issue;
      if (inflight) begin
        fifo_mem[wr_sel] <= tb_rd_data;
        wr_sel           <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      if (accept) wcnt <= wcnt + CNT_ONE;
    end
  end

endmodule
